// File: rtl/down_counter_timer_pkg.sv
// down_counter_timer_pkg: shared state encodings and mode constants for the down counter/timer
package down_counter_timer_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD = 1'b1;
endpackage

// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable down-counter with one-shot/auto-reload modes and terminal-count pulse
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             mode,
  input  logic             enable,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             zero,
  output logic             tc
);
  logic [1:0] state, state_nxt;
  logic [WIDTH-1:0] reload_reg, reload_nxt, q_nxt;
  logic mode_reg, mode_nxt, tc_nxt;
  logic last;
  assign last = (Q == WIDTH'(1));
  assign busy = (state == RUN);
  assign zero = (Q == '0);
  // next-state: load beats enable; terminal edge either reloads or parks in DONE
  always_comb begin
    state_nxt = (state == RUN || state == DONE) ? state : IDLE;
    q_nxt = Q;
    reload_nxt = reload_reg;
    mode_nxt = mode_reg;
    tc_nxt = 1'b0;
    if (load) begin
      q_nxt = load_value;
      reload_nxt = load_value;
      mode_nxt = mode;
      state_nxt = (load_value != '0) ? RUN : IDLE;
    end else if (state == RUN && enable && Q != '0) begin
      tc_nxt = last;
      q_nxt = !last ? Q - WIDTH'(1) : (mode_reg == MODE_RELOAD) ? reload_reg : '0;
      state_nxt = (last && mode_reg == MODE_ONESHOT) ? DONE : RUN;
    end
  end
  // registered datapath and FSM state; clear overrides everything
  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
      Q <= '0;
      reload_reg <= '0;
      mode_reg <= MODE_ONESHOT;
      tc <= 1'b0;
    end else begin
      state <= state_nxt;
      Q <= q_nxt;
      reload_reg <= reload_nxt;
      mode_reg <= mode_nxt;
      tc <= tc_nxt;
    end
  end
endmodule
